// File: rtl/decode_out_pkg_hdl.sv
// Shared definitions for the decode-stage output buffer: default field
// widths, the packed bundle type used by bus-functional models, and a
// helper that computes the flattened payload width.
package decode_out_pkg_hdl;

   localparam int DECODE_OUT_DATA_W   = 16;
   localparam int DECODE_OUT_NPC_W    = 16;
   localparam int DECODE_OUT_E_CTRL_W = 6;
   localparam int DECODE_OUT_W_CTRL_W = 2;
   localparam int DECODE_OUT_DEPTH    = 4;

   // One decoded instruction bundle at the default widths.
   typedef struct packed {
      logic [DECODE_OUT_DATA_W-1:0]   ir;
      logic [DECODE_OUT_NPC_W-1:0]    npc;
      logic [DECODE_OUT_E_CTRL_W-1:0] e_ctrl;
      logic [DECODE_OUT_W_CTRL_W-1:0] w_ctrl;
      logic                           mem_ctrl;
   } decode_out_bundle_t;

   // Width of a flattened {ir, npc, e_ctrl, w_ctrl, mem_ctrl} payload.
   function automatic int payload_width(input int data_w, input int npc_w,
                                        input int e_w, input int w_w);
      return data_w + npc_w + e_w + w_w + 1;
   endfunction

endpackage

// File: rtl/decode_out_buffer_if.sv
// Handshake bus between the decode datapath, the output buffer and the
// execute-stage input. The buffer takes the slave side; the driver of
// the decode side and consumer of the execute side takes the master side.
interface decode_out_buffer_if
   import decode_out_pkg_hdl::*;
#(
   parameter int DATA_W   = DECODE_OUT_DATA_W,
   parameter int NPC_W    = DECODE_OUT_NPC_W,
   parameter int E_CTRL_W = DECODE_OUT_E_CTRL_W,
   parameter int W_CTRL_W = DECODE_OUT_W_CTRL_W,
   parameter int DEPTH    = DECODE_OUT_DEPTH
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   // Upstream (decode) side
   logic                in_valid;
   logic                in_ready;
   logic [DATA_W-1:0]   in_ir;
   logic [NPC_W-1:0]    in_npc;
   logic [E_CTRL_W-1:0] in_e_ctrl;
   logic [W_CTRL_W-1:0] in_w_ctrl;
   logic                in_mem_ctrl;

   // Branch redirect squash
   logic                flush;

   // Downstream (execute) side
   logic                out_valid;
   logic                out_ready;
   logic [DATA_W-1:0]   out_ir;
   logic [NPC_W-1:0]    out_npc;
   logic [E_CTRL_W-1:0] out_e_ctrl;
   logic [W_CTRL_W-1:0] out_w_ctrl;
   logic                out_mem_ctrl;

   // Occupancy status
   logic [CNT_W-1:0]    count;
   logic                almost_full;

   modport master (
      output in_valid, in_ir, in_npc, in_e_ctrl, in_w_ctrl, in_mem_ctrl,
      output flush, out_ready,
      input  in_ready, out_valid, out_ir, out_npc, out_e_ctrl, out_w_ctrl,
      input  out_mem_ctrl, count, almost_full
   );

   modport slave (
      input  in_valid, in_ir, in_npc, in_e_ctrl, in_w_ctrl, in_mem_ctrl,
      input  flush, out_ready,
      output in_ready, out_valid, out_ir, out_npc, out_e_ctrl, out_w_ctrl,
      output out_mem_ctrl, count, almost_full
   );

endinterface

// File: rtl/decode_out_buffer_mem.sv
// DEPTH x WIDTH register array: one synchronous write port and one
// combinational read port. Entries are never cleared; the owner decides
// which entries are valid.
module decode_out_buffer_mem #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 41,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         // Each entry loads the write data when it is the addressed slot.
         always_ff @(posedge clock) begin
            if (i_wr_en && (i_wr_addr == AW'(gi))) begin
               r_mem[gi] <= i_wr_data;
            end
         end
      end
   endgenerate

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/decode_out_buffer.sv
// First-word-fall-through output buffer for decoded instruction bundles.
// Holds up to DEPTH bundles so a stalled execute stage can back-pressure
// decode. Head entry is presented combinationally; fields read as zero
// whenever the buffer is empty. flush discards everything and wins over
// any push or pop in the same cycle.
module decode_out_buffer
   import decode_out_pkg_hdl::*;
#(
   parameter int DATA_W   = DECODE_OUT_DATA_W,
   parameter int NPC_W    = DECODE_OUT_NPC_W,
   parameter int E_CTRL_W = DECODE_OUT_E_CTRL_W,
   parameter int W_CTRL_W = DECODE_OUT_W_CTRL_W,
   parameter int DEPTH    = DECODE_OUT_DEPTH
) (
   input logic               clock,
   input logic               reset,
   decode_out_buffer_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = payload_width(DATA_W, NPC_W, E_CTRL_W, W_CTRL_W);

   localparam logic [CW-1:0] FULL_COUNT   = CW'(DEPTH);
   localparam logic [CW-1:0] ALMOST_COUNT = CW'(DEPTH - 1);
   localparam logic [AW-1:0] PTR_ONE      = AW'(1);
   localparam logic [CW-1:0] CNT_ONE      = CW'(1);

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic          w_out_valid;
   logic          w_in_ready;
   logic          w_push;
   logic          w_pop;
   logic          w_wr_en;
   logic [PW-1:0] w_wr_data;
   logic [PW-1:0] w_rd_data;

   logic [DATA_W-1:0]   w_rd_ir;
   logic [NPC_W-1:0]    w_rd_npc;
   logic [E_CTRL_W-1:0] w_rd_e_ctrl;
   logic [W_CTRL_W-1:0] w_rd_w_ctrl;
   logic                w_rd_mem_ctrl;

   // Handshake qualifiers. A full buffer still accepts when the head is
   // leaving in the same cycle, which keeps one-per-cycle throughput.
   assign w_out_valid = (r_count != '0);
   assign w_pop       = w_out_valid && bus.out_ready;
   assign w_in_ready  = !reset && ((r_count < FULL_COUNT) || w_pop);
   assign w_push      = bus.in_valid && w_in_ready;

   // A bundle presented during a flush is dropped, so it must not land
   // in storage either.
   assign w_wr_en   = w_push && !bus.flush;
   assign w_wr_data = {bus.in_ir, bus.in_npc, bus.in_e_ctrl,
                       bus.in_w_ctrl, bus.in_mem_ctrl};

   decode_out_buffer_mem #(
      .DEPTH (DEPTH),
      .WIDTH (PW)
   ) u_mem (
      .clock     (clock),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (w_wr_data),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_rd_data)
   );

   // Pointers and occupancy; flush has priority over push and pop.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (bus.flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   assign {w_rd_ir, w_rd_npc, w_rd_e_ctrl, w_rd_w_ctrl, w_rd_mem_ctrl} = w_rd_data;

   // Head entry is masked to zero when empty so stale slots never leak out.
   assign bus.out_valid    = w_out_valid;
   assign bus.out_ir       = w_out_valid ? w_rd_ir       : '0;
   assign bus.out_npc      = w_out_valid ? w_rd_npc      : '0;
   assign bus.out_e_ctrl   = w_out_valid ? w_rd_e_ctrl   : '0;
   assign bus.out_w_ctrl   = w_out_valid ? w_rd_w_ctrl   : '0;
   assign bus.out_mem_ctrl = w_out_valid ? w_rd_mem_ctrl : 1'b0;

   assign bus.in_ready    = w_in_ready;
   assign bus.count       = r_count;
   assign bus.almost_full = (r_count >= ALMOST_COUNT);

endmodule

// File: tb/tb_decode_out_buffer.sv
// Directed bench for decode_out_buffer: a table of single-cycle vectors
// for the default DEPTH=4 instance, hand-written sequences for reset,
// and fill/drain runs on DEPTH=2 and DEPTH=16 instances with 32-bit words.
module tb_decode_out_buffer;
   import decode_out_pkg_hdl::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   decode_out_buffer_if #(.DEPTH(4)) bus ();
   decode_out_buffer_if #(.DATA_W(32), .DEPTH(2)) bus2 ();
   decode_out_buffer_if #(.DATA_W(32), .DEPTH(16)) bus16 ();

   decode_out_buffer #(.DEPTH(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   decode_out_buffer #(.DATA_W(32), .DEPTH(2)) dut2 (
      .clock (clock),
      .reset (reset),
      .bus   (bus2)
   );

   decode_out_buffer #(.DATA_W(32), .DEPTH(16)) dut16 (
      .clock (clock),
      .reset (reset),
      .bus   (bus16)
   );

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic        in_valid;
      logic [15:0] in_ir;
      logic        flush;
      logic        out_ready;
      logic        exp_valid;
      logic [15:0] exp_ir;
      int          exp_count;
      logic        exp_af;
      logic        exp_rdy;
   } vec_t;

   localparam int NV = 17;
   vec_t tbl [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic decode_out_bundle_t make_bundle(input logic [15:0] ir);
      decode_out_bundle_t b;
      b.ir       = ir;
      b.npc      = ~ir;
      b.e_ctrl   = ir[5:0];
      b.w_ctrl   = ir[1:0];
      b.mem_ctrl = ir[0];
      return b;
   endfunction

   task automatic drive(input logic [15:0] ir);
      decode_out_bundle_t b;
      b = make_bundle(ir);
      bus.in_ir       = b.ir;
      bus.in_npc      = b.npc;
      bus.in_e_ctrl   = b.e_ctrl;
      bus.in_w_ctrl   = b.w_ctrl;
      bus.in_mem_ctrl = b.mem_ctrl;
   endtask

   task automatic idle_all();
      bus.in_valid    = 1'b0;
      bus.flush       = 1'b0;
      bus.out_ready   = 1'b0;
      bus2.in_valid   = 1'b0;
      bus2.flush      = 1'b0;
      bus2.out_ready  = 1'b0;
      bus16.in_valid  = 1'b0;
      bus16.flush     = 1'b0;
      bus16.out_ready = 1'b0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Checks every head field against the bundle built from exp_ir, or zero.
   task automatic chk_head(input string tag, input logic exp_valid, input logic [15:0] exp_ir);
      decode_out_bundle_t e;
      e = exp_valid ? make_bundle(exp_ir) : '0;
      chk({tag, "_valid"}, 64'(bus.out_valid), 64'(exp_valid));
      chk({tag, "_ir"},    64'(bus.out_ir), 64'(e.ir));
      chk({tag, "_npc"},   64'(bus.out_npc), 64'(e.npc));
      chk({tag, "_ectl"},  64'(bus.out_e_ctrl), 64'(e.e_ctrl));
      chk({tag, "_wctl"},  64'(bus.out_w_ctrl), 64'(e.w_ctrl));
      chk({tag, "_mem"},   64'(bus.out_mem_ctrl), 64'(e.mem_ctrl));
   endtask

   initial begin
      // in_valid ir flush out_ready | valid ir count af rdy
      tbl[0]  = '{1'b1, 16'h1000, 1'b0, 1'b0, 1'b1, 16'h1000, 1, 1'b0, 1'b1};
      tbl[1]  = '{1'b1, 16'h1001, 1'b0, 1'b0, 1'b1, 16'h1000, 2, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 16'h1002, 1'b0, 1'b0, 1'b1, 16'h1000, 3, 1'b1, 1'b1};
      tbl[3]  = '{1'b1, 16'h1003, 1'b0, 1'b0, 1'b1, 16'h1000, 4, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 16'h1004, 1'b0, 1'b0, 1'b1, 16'h1000, 4, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 16'h2000, 1'b0, 1'b1, 1'b1, 16'h1001, 4, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1002, 3, 1'b1, 1'b1};
      tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1003, 2, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h2000, 1, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 16'h1010, 1'b0, 1'b0, 1'b1, 16'h1010, 1, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 16'h1011, 1'b0, 1'b1, 1'b1, 16'h1011, 1, 1'b0, 1'b1};
      tbl[13] = '{1'b1, 16'h1012, 1'b0, 1'b0, 1'b1, 16'h1011, 2, 1'b0, 1'b1};
      tbl[14] = '{1'b1, 16'h3000, 1'b1, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 1'b1};
      tbl[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b1};
      tbl[16] = '{1'b1, 16'h1020, 1'b0, 1'b0, 1'b1, 16'h1020, 1, 1'b0, 1'b1};

      idle_all();
      drive(16'h0000);
      bus2.in_ir = '0; bus2.in_npc = '0; bus2.in_e_ctrl = '0;
      bus2.in_w_ctrl = '0; bus2.in_mem_ctrl = 1'b0;
      bus16.in_ir = '0; bus16.in_npc = '0; bus16.in_e_ctrl = '0;
      bus16.in_w_ctrl = '0; bus16.in_mem_ctrl = 1'b0;

      // Reset state
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_count", 64'(bus.count), 64'd0);
      chk("rst_af", 64'(bus.almost_full), 64'd0);
      chk_head("rst", 1'b0, 16'h0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rel_in_ready", 64'(bus.in_ready), 64'd1);

      // Table-driven vectors on the DEPTH=4 instance
      for (int i = 0; i < NV; i++) begin
         bus.in_valid  = tbl[i].in_valid;
         drive(tbl[i].in_ir);
         bus.flush     = tbl[i].flush;
         bus.out_ready = tbl[i].out_ready;
         tick();
         idle_all();
         #1;
         chk_head($sformatf("v%0d", i), tbl[i].exp_valid, tbl[i].exp_ir);
         chk($sformatf("v%0d_count", i), 64'(bus.count), 64'(tbl[i].exp_count));
         chk($sformatf("v%0d_af", i), 64'(bus.almost_full), 64'(tbl[i].exp_af));
         chk($sformatf("v%0d_rdy", i), 64'(bus.in_ready), 64'(tbl[i].exp_rdy));
         $display("vec %0d: ir=%h count=%0d valid=%0b", i, bus.out_ir, bus.count, bus.out_valid);
      end

      // Async reset between edges at count=3
      bus.in_valid = 1'b1;
      drive(16'h1021);
      tick();
      drive(16'h1022);
      tick();
      bus.in_valid = 1'b0;
      #1;
      chk("pre_rst_count", 64'(bus.count), 64'd3);
      reset = 1'b1;
      #1;
      chk("arst_valid", 64'(bus.out_valid), 64'd0);
      chk("arst_count", 64'(bus.count), 64'd0);
      chk("arst_rdy", 64'(bus.in_ready), 64'd0);
      chk("arst_ir", 64'(bus.out_ir), 64'd0);
      #1;
      reset = 1'b0;
      bus.in_valid = 1'b1;
      drive(16'h4000);
      #1;
      chk("post_rst_rdy", 64'(bus.in_ready), 64'd1);
      chk("no_bypass", 64'(bus.out_valid), 64'd0);
      tick();
      bus.in_valid = 1'b0;
      #1;
      chk_head("post_rst", 1'b1, 16'h4000);
      chk("post_rst_count", 64'(bus.count), 64'd1);
      $display("arst: first push ir=%h count=%0d", bus.out_ir, bus.count);

      // DEPTH=2, 32-bit words: fill past full, then drain
      for (int i = 0; i < 3; i++) begin
         bus2.in_valid = 1'b1;
         bus2.in_ir    = 32'hA000_0000 + 32'(i);
         tick();
         bus2.in_valid = 1'b0;
         #1;
         chk($sformatf("d2_fill%0d_count", i), 64'(bus2.count), 64'((i < 2) ? i + 1 : 2));
         chk($sformatf("d2_fill%0d_rdy", i), 64'(bus2.in_ready), 64'(i < 1));
         chk($sformatf("d2_fill%0d_af", i), 64'(bus2.almost_full), 64'd1);
         chk($sformatf("d2_fill%0d_ir", i), 64'(bus2.out_ir), 64'h0A00_0000 * 16);
         $display("d2 fill %0d: count=%0d", i, bus2.count);
      end
      for (int i = 0; i < 2; i++) begin
         bus2.out_ready = 1'b1;
         #1;
         chk($sformatf("d2_drain%0d_ir", i), 64'(bus2.out_ir), 64'(32'hA000_0000 + 32'(i)));
         tick();
         bus2.out_ready = 1'b0;
         $display("d2 drain %0d", i);
      end
      #1;
      chk("d2_empty_valid", 64'(bus2.out_valid), 64'd0);
      chk("d2_empty_ir", 64'(bus2.out_ir), 64'd0);
      chk("d2_empty_count", 64'(bus2.count), 64'd0);

      // DEPTH=16, 32-bit words: fill to full, refused extra push, drain
      for (int i = 0; i < 17; i++) begin
         bus16.in_valid = 1'b1;
         bus16.in_ir    = 32'h0000_5000 + 32'(i);
         tick();
         bus16.in_valid = 1'b0;
         #1;
         chk($sformatf("d16_fill%0d_count", i), 64'(bus16.count), 64'((i < 16) ? i + 1 : 16));
         chk($sformatf("d16_fill%0d_rdy", i), 64'(bus16.in_ready), 64'(i < 15));
         chk($sformatf("d16_fill%0d_af", i), 64'(bus16.almost_full), 64'(i >= 14));
         $display("d16 fill %0d: count=%0d", i, bus16.count);
      end
      for (int i = 0; i < 16; i++) begin
         bus16.out_ready = 1'b1;
         #1;
         chk($sformatf("d16_drain%0d_ir", i), 64'(bus16.out_ir), 64'(32'h0000_5000 + 32'(i)));
         tick();
         bus16.out_ready = 1'b0;
         $display("d16 drain %0d", i);
      end
      #1;
      chk("d16_empty_valid", 64'(bus16.out_valid), 64'd0);
      chk("d16_empty_count", 64'(bus16.count), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/decode_out_buffer.md
# decode_out_buffer

Parametrised, first-word-fall-through output buffer for the decode stage. It captures each decoded instruction bundle (instruction word, next PC, execute/writeback/memory control) on a valid/ready handshake and holds up to DEPTH bundles. This lets a stalled execute stage back-pressure decode without losing instructions. It sits between the decode datapath and the execute-stage input. The decode_out agent monitors its output port.

## Interface
- DATA_W, 16: instruction word width.
- NPC_W, 16: next-PC width.
- E_CTRL_W, 6: execute control width.
- W_CTRL_W, 2: writeback control width.
- DEPTH, 4: entries; power of two, ≥2.
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset; clears all state immediately.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  buffer accepts this cycle.
- in_ir / in_npc / in_e_ctrl / in_w_ctrl / in_mem_ctrl  in  DATA_W / NPC_W / E_CTRL_W / W_CTRL_W / 1  bundle fields.
- flush  in  1  discard all held entries (branch redirect).
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream consumes head.
- out_ir / out_npc / out_e_ctrl / out_w_ctrl / out_mem_ctrl  out  same widths  head entry fields.
- count  out  $clog2(DEPTH+1)  occupancy.
- almost_full  out  1  count ≥ DEPTH-1.

## Operation
- Push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = !reset && (count < DEPTH || pop). A full buffer accepts a push in a cycle that pops.
- Storage is a circular array with write pointer wr_ptr and read pointer rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH. count is tracked separately, not derived from the pointers.
- Push writes the bundle at wr_ptr and increments wr_ptr. Pop increments rd_ptr.
- count update: +1 on push only, −1 on pop only, unchanged on push and pop together.
- out_* fields show the entry at rd_ptr combinationally (FWFT). When out_valid=0, out_* fields are 0, not stale data.
- flush has priority. In a flush cycle: pointers and count go to 0, and any push or pop in that cycle is ignored (a bundle presented is dropped). in_ready still follows the formula above; upstream must treat a flush-cycle handshake as squashed.
- Empty: out_valid=0 and out_ready is ignored. Full (count=DEPTH) with no pop: in_ready=0 and in_valid is ignored.
- Reset mid-operation: all entries are logically discarded at once. Storage contents need no clearing; validity is governed by count.

## Timing
- Reset values (asynchronous): count=0, almost_full=0, out_valid=0, all out_* fields 0, in_ready=0 while reset is high and 1 in the first cycle after release.
- Latency: a bundle pushed at edge N is visible on out_* with out_valid=1 after edge N (usable in cycle N+1). There is no same-cycle input-to-output bypass.
- A bundle popped at edge N is replaced by the next entry, or out_valid goes 0, after edge N.
- Throughput: one push and one pop per cycle sustained at any occupancy.
- almost_full and count are registered-derived; they change only after a clock edge or reset.
- flush sampled at edge N: out_valid=0 and count=0 after edge N.

## Structure
- Shared package decode_out_pkg_hdl holds:
  - default width constants (DECODE_OUT_DATA_W, _NPC_W, _E_CTRL_W, _W_CTRL_W);
  - a packed payload typedef decode_out_bundle_t built from those defaults, used by the BFMs.
- Natural sub-module: decode_out_buffer_mem, a DEPTH × payload-width register array with one write port and one combinational read port. The top level holds the pointers, count, handshake and flush logic.

## Test plan
- Reset/fill: after reset, push 4 bundles (in_ir=16'h1000..16'h1003) with out_ready=0 -> count 1,2,3,4; almost_full asserts at count=3; in_ready=0 at count=4; out_ir=16'h1000 throughout.
- Drain order: from the full state, hold out_ready=1 for 4 cycles -> out_ir sequence 1000,1001,1002,1003; then out_valid=0, all out_* fields 0, count=0.
- Full push+pop: at count=4, in_valid=1 and out_ready=1 with in_ir=16'h2000 -> push accepted, count stays 4, 16'h2000 becomes the last entry; wrap-around of wr_ptr verified.
- Flush priority: at count=2, assert flush with in_valid=1 and out_ready=1 -> after the edge count=0 and out_valid=0; the 16'h3000 bundle presented that cycle never appears at the output.
- Async reset mid-stream: assert reset between edges at count=3 -> out_valid, count and in_ready drop to 0 immediately; after release the first push (16'h4000) appears with a 1-cycle latency.
- Parameter sweep: DEPTH=2 and DEPTH=16, DATA_W=32 -> same ordering and full/empty behaviour; count width is 2 and 5 bits respectively.
